// File: rtl/eth_pkg.sv
// eth_pkg: Ethernet constants and route encoding
// shared by the transmit and receive protocol muxes.
package eth_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [7:0]  IP_PROTO_ICMP = 8'h01;
  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;

  localparam int RX_DISPATCH_LAT = 33;

  typedef enum logic [1:0] {
    ROUTE_DROP = 2'd0,
    ROUTE_ARP  = 2'd1,
    ROUTE_UDP  = 2'd2,
    ROUTE_ICMP = 2'd3
  } route_t;

endpackage

// File: rtl/eth_rx_delay_line.sv
// eth_rx_delay_line: fixed-depth shift register of
// {dv, sof, data} beats holding frames while they are classified.
module eth_rx_delay_line
  import eth_pkg::*;
#(
  parameter int DEPTH = RX_DISPATCH_LAT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  output logic [9:0] dout
);

  logic [DEPTH-1:0][9:0] sr_q;
  logic [DEPTH-1:0][9:0] sr_d;

  // shift one beat per clock, newest beat at stage 0
  always_comb begin
    sr_d = {sr_q[DEPTH-2:0], din};
  end

  // stage registers, cleared so a reset discards in-flight frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/eth_rx_dispatch.sv
// eth_rx_dispatch: classifies GMII receive frames and forwards
// each whole frame to the ARP, UDP or ICMP receiver, or drops it.
module eth_rx_dispatch
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_dv,
  output logic [7:0]  arp_rxd,
  output logic        udp_rx_dv,
  output logic [7:0]  udp_rxd,
  output logic        icmp_rx_dv,
  output logic [7:0]  icmp_rxd,
  output logic [15:0] cnt_arp,
  output logic [15:0] cnt_udp,
  output logic [15:0] cnt_icmp,
  output logic [15:0] cnt_drop
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DECIDED
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  k_q, k_d;
  logic        loc_ok_q, loc_ok_d;
  logic        bc_ok_q, bc_ok_d;
  logic [7:0]  type_hi_q, type_hi_d;
  route_t      pend_q, pend_d;
  logic [15:0] cnt_arp_q, cnt_arp_d;
  logic [15:0] cnt_udp_q, cnt_udp_d;
  logic [15:0] cnt_icmp_q, cnt_icmp_d;
  logic [15:0] cnt_drop_q, cnt_drop_d;

  logic [5:0]  idx;
  logic [47:0] mac_sh;
  logic [7:0]  mac_b;
  logic [15:0] etype;
  logic        scan;
  logic        fail;
  logic        hit;
  route_t      hit_r;
  logic        dec;
  route_t      dec_r;

  // header scan: index tracking, frame checks, decision, counters
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    loc_ok_d   = loc_ok_q;
    bc_ok_d    = bc_ok_q;
    type_hi_d  = type_hi_q;
    pend_d     = pend_q;
    cnt_arp_d  = cnt_arp_q;
    cnt_udp_d  = cnt_udp_q;
    cnt_icmp_d = cnt_icmp_q;
    cnt_drop_d = cnt_drop_q;
    idx    = (state_q == S_IDLE) ? 6'd0 : k_q;
    mac_sh = LOCAL_MAC << {idx[2:0], 3'b000};
    mac_b  = mac_sh[47:40];
    etype  = {type_hi_q, gmii_rxd};
    scan   = gmii_rx_dv && (state_q != S_DECIDED);
    fail   = 1'b0;
    hit    = 1'b0;
    hit_r  = ROUTE_DROP;
    dec    = 1'b0;
    dec_r  = ROUTE_DROP;
    if (scan) begin
      unique case (1'b1)
        (idx <= 6'd6): begin
          fail = (gmii_rxd != ETH_PREAMBLE);
        end
        (idx == 6'd7): begin
          fail = (gmii_rxd != ETH_SFD);
        end
        (idx >= 6'd8 && idx <= 6'd13): begin
          loc_ok_d = ((idx == 6'd8) || loc_ok_q)
                     && (gmii_rxd == mac_b);
          bc_ok_d  = ((idx == 6'd8) || bc_ok_q)
                     && (gmii_rxd == 8'hFF);
          fail     = !(loc_ok_d || bc_ok_d);
        end
        (idx == 6'd20): begin
          type_hi_d = gmii_rxd;
        end
        (idx == 6'd21): begin
          if (etype == ETH_TYPE_ARP) begin
            hit   = 1'b1;
            hit_r = ROUTE_ARP;
          end else begin
            fail = (etype != ETH_TYPE_IPV4);
          end
        end
        (idx == 6'd22): begin
          fail = (gmii_rxd[7:4] != 4'd4);
        end
        (idx == 6'd31): begin
          if (gmii_rxd == IP_PROTO_UDP) begin
            hit   = 1'b1;
            hit_r = ROUTE_UDP;
          end else if (gmii_rxd == IP_PROTO_ICMP) begin
            hit   = 1'b1;
            hit_r = ROUTE_ICMP;
          end else begin
            fail = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (gmii_rx_dv) begin
      k_d = (idx == 6'd63) ? idx : idx + 6'd1;
      if (state_q != S_DECIDED) begin
        state_d = (hit || fail) ? S_DECIDED : S_HDR;
        dec     = hit || fail;
        dec_r   = hit ? hit_r : ROUTE_DROP;
      end
    end else begin
      state_d = S_IDLE;
      k_d     = 6'd0;
      if (state_q == S_HDR) begin
        dec   = 1'b1;
        dec_r = ROUTE_DROP;
      end
    end
    if (dec) begin
      pend_d = dec_r;
      unique case (dec_r)
        ROUTE_ARP:  cnt_arp_d  = cnt_arp_q + 16'd1;
        ROUTE_UDP:  cnt_udp_d  = cnt_udp_q + 16'd1;
        ROUTE_ICMP: cnt_icmp_d = cnt_icmp_q + 16'd1;
        ROUTE_DROP: cnt_drop_d = cnt_drop_q + 16'd1;
      endcase
    end
  end

  // classifier state and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      loc_ok_q   <= 1'b0;
      bc_ok_q    <= 1'b0;
      type_hi_q  <= '0;
      pend_q     <= ROUTE_DROP;
      cnt_arp_q  <= '0;
      cnt_udp_q  <= '0;
      cnt_icmp_q <= '0;
      cnt_drop_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      loc_ok_q   <= loc_ok_d;
      bc_ok_q    <= bc_ok_d;
      type_hi_q  <= type_hi_d;
      pend_q     <= pend_d;
      cnt_arp_q  <= cnt_arp_d;
      cnt_udp_q  <= cnt_udp_d;
      cnt_icmp_q <= cnt_icmp_d;
      cnt_drop_q <= cnt_drop_d;
    end
  end

  logic       sof;
  logic [9:0] line_in;
  logic [9:0] line_out;

  assign sof     = gmii_rx_dv && (state_q == S_IDLE);
  assign line_in = {gmii_rx_dv, sof,
                    gmii_rx_dv ? gmii_rxd : 8'h00};

  eth_rx_delay_line #(
    .DEPTH (RX_DISPATCH_LAT)
  ) u_line (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (line_in),
    .dout  (line_out)
  );

  route_t     act_q, act_d, sel_r;
  logic       arp_dv_q, arp_dv_d;
  logic [7:0] arp_d_q, arp_d_d;
  logic       udp_dv_q, udp_dv_d;
  logic [7:0] udp_d_q, udp_d_d;
  logic       icmp_dv_q, icmp_dv_d;
  logic [7:0] icmp_d_q, icmp_d_d;

  // route latches on exiting sof, then steers the frame to one port
  always_comb begin
    sel_r     = line_out[8] ? pend_q : act_q;
    act_d     = sel_r;
    arp_dv_d  = line_out[9] && (sel_r == ROUTE_ARP);
    arp_d_d   = (sel_r == ROUTE_ARP) ? line_out[7:0] : 8'h00;
    udp_dv_d  = line_out[9] && (sel_r == ROUTE_UDP);
    udp_d_d   = (sel_r == ROUTE_UDP) ? line_out[7:0] : 8'h00;
    icmp_dv_d = line_out[9] && (sel_r == ROUTE_ICMP);
    icmp_d_d  = (sel_r == ROUTE_ICMP) ? line_out[7:0] : 8'h00;
  end

  // registered output ports and active route
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q     <= ROUTE_DROP;
      arp_dv_q  <= 1'b0;
      arp_d_q   <= '0;
      udp_dv_q  <= 1'b0;
      udp_d_q   <= '0;
      icmp_dv_q <= 1'b0;
      icmp_d_q  <= '0;
    end else begin
      act_q     <= act_d;
      arp_dv_q  <= arp_dv_d;
      arp_d_q   <= arp_d_d;
      udp_dv_q  <= udp_dv_d;
      udp_d_q   <= udp_d_d;
      icmp_dv_q <= icmp_dv_d;
      icmp_d_q  <= icmp_d_d;
    end
  end

  assign arp_rx_dv  = arp_dv_q;
  assign arp_rxd    = arp_d_q;
  assign udp_rx_dv  = udp_dv_q;
  assign udp_rxd    = udp_d_q;
  assign icmp_rx_dv = icmp_dv_q;
  assign icmp_rxd   = icmp_d_q;
  assign cnt_arp    = cnt_arp_q;
  assign cnt_udp    = cnt_udp_q;
  assign cnt_icmp   = cnt_icmp_q;
  assign cnt_drop   = cnt_drop_q;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// tb_eth_rx_dispatch: frame-level reference model and
// cycle-by-cycle stream scoreboard for eth_rx_dispatch.
`timescale 1ns/1ps
module tb_eth_rx_dispatch;
  import eth_pkg::*;

  localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;
  localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] FOR = 48'h0200_0000_0001;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic       dv;
    logic [7:0] d;
    logic [1:0] r;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gmii_rx_dv = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        arp_rx_dv, udp_rx_dv, icmp_rx_dv;
  logic [7:0]  arp_rxd, udp_rxd, icmp_rxd;
  logic [15:0] cnt_arp, cnt_udp, cnt_icmp, cnt_drop;

  eth_rx_dispatch #(.LOCAL_MAC(MAC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rxd   (gmii_rxd),
    .arp_rx_dv  (arp_rx_dv),
    .arp_rxd    (arp_rxd),
    .udp_rx_dv  (udp_rx_dv),
    .udp_rxd    (udp_rxd),
    .icmp_rx_dv (icmp_rx_dv),
    .icmp_rxd   (icmp_rxd),
    .cnt_arp    (cnt_arp),
    .cnt_udp    (cnt_udp),
    .cnt_icmp   (cnt_icmp),
    .cnt_drop   (cnt_drop)
  );

  always #4 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          seen[4];
  int          in_rise = 0;
  int          arp_rise = 0;
  logic        prev_in = 1'b0;
  logic        prev_arp = 1'b0;
  logic [1:0]  cur_r = 2'd0;
  logic [15:0] exp_cnt[4];
  ent_t        hist[$];

  // route a frame from its bytes alone
  function automatic int classify(input byte_q_t f);
    logic loc;
    logic bc;
    logic [15:0] et;
    loc = 1'b1;
    bc  = 1'b1;
    if (f.size() < 22) return 0;
    for (int i = 0; i < 7; i++)
      if (f[i] != 8'h55) return 0;
    if (f[7] != 8'hD5) return 0;
    for (int i = 0; i < 6; i++) begin
      loc = loc && (f[8+i] == MAC[47-8*i -: 8]);
      bc  = bc && (f[8+i] == 8'hFF);
    end
    if (!(loc || bc)) return 0;
    et = {f[20], f[21]};
    if (et == 16'h0806) return 1;
    if (et != 16'h0800 || f.size() < 32) return 0;
    if (f[22][7:4] != 4'd4) return 0;
    if (f[31] == 8'h11) return 2;
    if (f[31] == 8'h01) return 3;
    return 0;
  endfunction

  function automatic byte_q_t mk(input logic [47:0] da,
                                 input logic [15:0] et,
                                 input logic [7:0] ver,
                                 input logic [7:0] pr,
                                 input int len);
    byte_q_t q;
    for (int i = 0; i < 7; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) q.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) q.push_back(8'(8'h02 + i));
    q.push_back(et[15:8]);
    q.push_back(et[7:0]);
    q.push_back(ver);
    while (q.size() < 32 || q.size() < len)
      q.push_back(8'($urandom));
    q[31] = pr;
    while (q.size() > len) void'(q.pop_back());
    return q;
  endfunction

  task automatic chk(input string nm, input logic [47:0] got,
                     input logic [47:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // per-cycle stream compare against the delayed model stream
  task automatic score();
    ent_t h;
    ent_t e;
    logic a_dv[4];
    logic [7:0] a_d[4];
    logic ok;
    logic want;
    cyc++;
    if (!rst_n) begin
      hist.delete();
      repeat (RX_DISPATCH_LAT) hist.push_back('0);
      prev_in = 1'b0;
      return;
    end
    if (gmii_rx_dv && !prev_in) in_rise = cyc;
    prev_in = gmii_rx_dv;
    if (arp_rx_dv && !prev_arp) arp_rise = cyc;
    prev_arp = arp_rx_dv;
    e.dv = gmii_rx_dv;
    e.d  = gmii_rxd;
    e.r  = cur_r;
    hist.push_back(e);
    h = hist.pop_front();
    a_dv[0] = 1'b0;       a_d[0] = 8'h00;
    a_dv[1] = arp_rx_dv;  a_d[1] = arp_rxd;
    a_dv[2] = udp_rx_dv;  a_d[2] = udp_rxd;
    a_dv[3] = icmp_rx_dv; a_d[3] = icmp_rxd;
    ok = 1'b1;
    for (int p = 1; p < 4; p++) begin
      want = h.dv && (h.r == 2'(p));
      if (a_dv[p] != want) ok = 1'b0;
      if (want && a_d[p] != h.d) ok = 1'b0;
      if (h.dv && !want && a_d[p] != 8'h00) ok = 1'b0;
      seen[p] += int'(a_dv[p]);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL stream cyc=%0d got dv=%b%b%b d=%h/%h/%h want dv=%b d=%h route=%0d",
               cyc, arp_rx_dv, udp_rx_dv, icmp_rx_dv,
               arp_rxd, udp_rxd, icmp_rxd, h.dv, h.d, h.r);
    end
  endtask

  task automatic tick(input logic dv, input logic [7:0] d,
                      input logic [1:0] r);
    @(negedge clk);
    gmii_rx_dv = dv;
    gmii_rxd   = d;
    cur_r      = r;
    @(posedge clk);
    #1;
    score();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'($urandom), 2'd0);
  endtask

  task automatic send(input byte_q_t f, input int gap);
    int r;
    r = classify(f);
    exp_cnt[r] = exp_cnt[r] + 16'd1;
    foreach (f[i]) tick(1'b1, f[i], 2'(r));
    idle(gap);
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_arp"},  cnt_arp,  exp_cnt[1]);
    chk({nm, "_udp"},  cnt_udp,  exp_cnt[2]);
    chk({nm, "_icmp"}, cnt_icmp, exp_cnt[3]);
    chk({nm, "_drop"}, cnt_drop, exp_cnt[0]);
  endtask

  int s1, s2, s3, n;
  byte_q_t fq, rest;
  logic [47:0] da;
  logic [15:0] et;
  logic [7:0] ver, pr;
  int len, j, r;

  initial begin
    for (int i = 0; i < 4; i++) begin
      seen[i] = 0;
      exp_cnt[i] = 16'd0;
    end
    idle(4);
    chk("rst_dv", {arp_rx_dv, udp_rx_dv, icmp_rx_dv}, 0);
    chk("rst_data", {arp_rxd, udp_rxd, icmp_rxd}, 0);
    chk("rst_cnt", {cnt_arp, cnt_udp, cnt_icmp}, 0);
    chk("rst_drop", cnt_drop, 0);
    #2 rst_n = 1'b1;
    idle(5);

    s1 = seen[1]; s2 = seen[2]; s3 = seen[3];
    send(mk(BC, 16'h0806, 8'h00, 8'h00, 68), 12);
    idle(40);
    chk("arp_len", seen[1] - s1, 68);
    chk("arp_lat", arp_rise - in_rise, 33);
    chk("arp_other", (seen[2] - s2) + (seen[3] - s3), 0);
    chk("arp_cnt", cnt_arp, 1);

    s1 = seen[1]; s2 = seen[2]; s3 = seen[3];
    send(mk(MAC, 16'h0800, 8'h45, 8'h11, 100), 12);
    idle(40);
    chk("udp_len", seen[2] - s2, 100);
    chk("udp_cnt", cnt_udp, 1);
    chk("udp_cnt_other", {cnt_icmp, cnt_drop}, 0);

    s1 = seen[1]; s2 = seen[2]; s3 = seen[3];
    send(mk(MAC, 16'h0800, 8'h45, 8'h01, 70), 12);
    send(mk(BC, 16'h0800, 8'h45, 8'h11, 64), 12);
    idle(40);
    chk("pair_icmp_len", seen[3] - s3, 70);
    chk("pair_udp_len", seen[2] - s2, 64);
    chk("pair_icmp_cnt", cnt_icmp, 1);
    chk("pair_udp_cnt", cnt_udp, 2);

    s1 = seen[1]; s2 = seen[2]; s3 = seen[3];
    send(mk(FOR, 16'h0800, 8'h45, 8'h11, 80), 12);
    send(mk(MAC, 16'h86DD, 8'h60, 8'h11, 80), 12);
    send(mk(MAC, 16'h0800, 8'h45, 8'h06, 80), 12);
    send(mk(MAC, 16'h0800, 8'h45, 8'h11, 20), 12);
    idle(40);
    chk("drop_cnt", cnt_drop, 4);
    chk("drop_quiet", (seen[1] - s1) + (seen[2] - s2)
                      + (seen[3] - s3), 0);
    chk_model("fixed");

    for (n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: da = MAC;
        1: da = BC;
        2: da = FOR;
        3: da = 48'hFFFF_2233_4455;
        default: da = MAC;
      endcase
      case ($urandom_range(0, 3))
        0: et = 16'h0806;
        3: et = 16'h86DD;
        default: et = 16'h0800;
      endcase
      ver = ($urandom_range(0, 5) == 0) ? 8'h65 : 8'h45;
      case ($urandom_range(0, 3))
        0: pr = 8'h01;
        1: pr = 8'h06;
        default: pr = 8'h11;
      endcase
      len = $urandom_range(20, 90);
      fq = mk(da, et, ver, pr, len);
      if ($urandom_range(0, 7) == 0) begin
        j = $urandom_range(0, 7);
        fq[j] = fq[j] ^ 8'h10;
      end
      send(fq, $urandom_range(12, 20));
    end
    idle(40);
    chk_model("rand");

    s2 = seen[2];
    send(mk(BC, 16'h0806, 8'h00, 8'h00, 68), 12);
    fq = mk(MAC, 16'h0800, 8'h45, 8'h11, 80);
    for (int i = 0; i < 16; i++) tick(1'b1, fq[i], 2'd2);
    chk("pre_rst_arp", arp_rx_dv, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_dv", {arp_rx_dv, udp_rx_dv, icmp_rx_dv}, 0);
    chk("mid_rst_data", {arp_rxd, udp_rxd, icmp_rxd}, 0);
    chk("mid_rst_cnt", {cnt_arp, cnt_udp, cnt_icmp}, 0);
    for (int i = 0; i < 4; i++) exp_cnt[i] = 16'd0;
    tick(1'b1, fq[16], 2'd0);
    tick(1'b1, fq[17], 2'd0);
    #1 rst_n = 1'b1;
    rest = fq[18:$];
    r = classify(rest);
    exp_cnt[r] = exp_cnt[r] + 16'd1;
    foreach (rest[i]) tick(1'b1, rest[i], 2'(r));
    idle(12);
    send(mk(BC, 16'h0806, 8'h00, 8'h00, 60), 12);
    idle(40);
    chk("post_rst_udp", seen[2] - s2, 0);
    chk("post_rst_arp", cnt_arp, 1);
    chk("post_rst_drop", cnt_drop, 1);
    chk_model("post_rst");

    force dut.cnt_arp_q = 16'hFFFF;
    idle(1);
    release dut.cnt_arp_q;
    idle(1);
    chk("wrap_pre", cnt_arp, 16'hFFFF);
    exp_cnt[1] = 16'hFFFF;
    send(mk(MAC, 16'h0806, 8'h00, 8'h00, 68), 12);
    idle(40);
    chk("wrap_zero", cnt_arp, 16'h0000);
    chk_model("wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
